// File: rtl/mem_stream_reader.sv
// mem_stream_reader: drains per-block memories in priority-encoder order into one stream.
// Revision 1.0
`default_nettype none

module mem_stream_reader #(
  parameter int NMEM   = 12,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 36
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [NMEM*(ADDR_W+1)-1:0] nent,
  output logic [NMEM-1:0]          has_dat,
  input  logic [3:0]               sel,
  input  logic                     none,
  output logic [NMEM-1:0]          rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [NMEM*DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]        out_data,
  output logic [3:0]               out_blk,
  output logic                     out_valid,
  output logic                     done,
  output logic                     err
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]   MAXN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CW-1:0]   ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [NMEM-1:0] ONEHOT = {{(NMEM-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_DECIDE = 3'd2,
    S_READ   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state;
  logic            settle;
  logic [3:0]      blk;
  logic [CW-1:0]   rem  [NMEM];
  logic [CW-1:0]   nsat [NMEM];
  logic            dec_ok;
  logic            dec_empty;
  logic [3:0]      dec_blk;
  logic            v1;
  logic [3:0]      blk1;
  logic            pipe_idle;

  always_comb begin
    for (int i = 0; i < NMEM; i++) begin
      nsat[i] = nent[i*CW +: CW];
      if (nsat[i] > MAXN) nsat[i] = MAXN;
    end
  end

  // Code 1010 is skipped by the encoder, so blocks 10/11 sit at 1011/1100.
  always_comb begin
    dec_ok  = 1'b1;
    dec_blk = sel;
    case (sel)
      4'd10:               dec_ok  = 1'b0;
      4'd11:               dec_blk = 4'd10;
      4'd12:               dec_blk = 4'd11;
      4'd13, 4'd14, 4'd15: dec_ok  = 1'b0;
      default:             ;
    endcase
    dec_empty = 1'b1;
    for (int i = 0; i < NMEM; i++)
      if (4'(i) == dec_blk) dec_empty = (rem[i] == '0);
  end

  assign pipe_idle = (rd_en == '0) && !v1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      settle  <= 1'b0;
      blk     <= '0;
      rd_en   <= '0;
      rd_addr <= '0;
      has_dat <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      for (int i = 0; i < NMEM; i++) rem[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NMEM; i++) begin
              rem[i]     <= nsat[i];
              has_dat[i] <= (nsat[i] != '0);
            end
            err    <= 1'b0;
            settle <= 1'b0;
            state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle) state <= S_DECIDE;
          else        settle <= 1'b1;
        end
        S_DECIDE: begin
          if (none) begin
            if (pipe_idle) done <= 1'b1;
            state <= S_DONE;
          end else if (!dec_ok || dec_empty) begin
            err     <= 1'b1;
            has_dat <= '0;
            for (int i = 0; i < NMEM; i++) rem[i] <= '0;
            if (pipe_idle) done <= 1'b1;
            state <= S_DONE;
          end else begin
            blk     <= dec_blk;
            rd_addr <= '0;
            rd_en   <= ONEHOT << dec_blk;
            state   <= S_READ;
          end
        end
        S_READ: begin
          rem[blk] <= rem[blk] - ONE;
          rd_addr  <= rd_addr + 1'b1;
          if (rem[blk] <= ONE) begin
            has_dat[blk] <= 1'b0;
            rd_en        <= '0;
            settle       <= 1'b0;
            state        <= S_SETTLE;
          end
        end
        S_DONE: begin
          if (done)           state <= S_IDLE;
          else if (pipe_idle) done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Return pipe runs independently so reads issued on the last READ cycle still land.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1        <= 1'b0;
      blk1      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_blk   <= '0;
    end else begin
      v1        <= (rd_en != '0);
      blk1      <= blk;
      out_valid <= v1;
      if (v1) begin
        out_data <= rd_data[blk1*DATA_W +: DATA_W];
        out_blk  <= blk1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: encoder/memory models around the DUT, schedule-based reference model.
// Revision 1.0
`default_nettype none

module tb_mem_stream_reader;

  localparam int NMEM = 12;
  localparam int AW   = 6;
  localparam int DW   = 36;
  localparam int CW   = AW + 1;
  localparam int MAXC = 1024;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic [NMEM*CW-1:0]   nent = '0;
  logic [NMEM-1:0]      has_dat;
  logic [3:0]           sel = 4'd0;
  logic                 none = 1'b1;
  logic [NMEM-1:0]      rd_en;
  logic [AW-1:0]        rd_addr;
  logic [NMEM*DW-1:0]   rd_data = '0;
  logic [DW-1:0]        out_data;
  logic [3:0]           out_blk;
  logic                 out_valid;
  logic                 done;
  logic                 err;

  always #5 clk = ~clk;

  mem_stream_reader #(.NMEM(NMEM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .nent(nent), .has_dat(has_dat),
    .sel(sel), .none(none), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_blk(out_blk), .out_valid(out_valid), .done(done), .err(err)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0]     seed = 32'd0;
  logic [4:0]      force_code = 5'd0;
  logic [NMEM-1:0] enc1 = '0;

  // Encoder: two register stages, lowest index wins, blocks 10/11 coded 1011/1100.
  function automatic logic [3:0] enc_code(input logic [NMEM-1:0] h);
    enc_code = 4'd0;
    for (int b = NMEM - 1; b >= 0; b--)
      if (h[b]) enc_code = (b == 10) ? 4'd11 : (b == 11) ? 4'd12 : 4'(b);
  endfunction

  always @(posedge clk) begin
    enc1 <= has_dat;
    if (force_code[4]) begin
      sel  <= force_code[3:0];
      none <= 1'b0;
    end else begin
      sel  <= enc_code(enc1);
      none <= (enc1 == '0);
    end
  end

  function automatic logic [DW-1:0] mem_word(input int b, input int a);
    logic [31:0] t;
    t = seed ^ (32'(b) * 32'h9E3779B1) ^ (32'(a) * 32'h85EBCA6B);
    return {4'(b), 6'(a), t[25:0]};
  endfunction

  // Memories answer one cycle after rd_en; idle blocks present noise.
  always @(posedge clk) begin
    for (int b = 0; b < NMEM; b++) begin
      if (rd_en[b]) rd_data[b*DW +: DW] <= mem_word(b, int'(rd_addr));
      else          rd_data[b*DW +: DW] <= DW'({$urandom(), $urandom()});
    end
  end

  int              ev_n [NMEM];
  logic [NMEM-1:0] e_rden [MAXC];
  logic [AW-1:0]   e_addr [MAXC];
  logic            e_ov   [MAXC];
  logic [3:0]      e_ob   [MAXC];
  logic [DW-1:0]   e_od   [MAXC];
  int              hd_last [NMEM];
  int              done_cyc, err_from, end_cyc;

  int obs_nout, obs_done, obs_ndone, obs_first_ov, obs_last_addr;
  int obs_first_rd [NMEM];
  int obs_blks [$];

  task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  // Schedule: blocks served in ascending order, n reads each, 3 dead cycles between blocks.
  // Forced codes used in this bench are always error cases (illegal or empty block).
  task automatic build_model(input logic [4:0] fc);
    int t, last, n;
    for (int c = 0; c < MAXC; c++) begin
      e_rden[c] = '0; e_addr[c] = '0; e_ov[c] = 1'b0; e_ob[c] = '0; e_od[c] = '0;
    end
    err_from = MAXC;
    t = 4;
    last = 0;
    for (int b = 0; b < NMEM; b++) begin
      n = (ev_n[b] > 64) ? 64 : ev_n[b];
      hd_last[b] = 0;
      if (fc[4]) begin
        if (n > 0) hd_last[b] = 3;
      end else if (n > 0) begin
        for (int k = 0; k < n; k++) begin
          e_rden[t+k]   = NMEM'(1) << b;
          e_addr[t+k]   = AW'(k);
          e_ov[t+k+2]   = 1'b1;
          e_ob[t+k+2]   = 4'(b);
          e_od[t+k+2]   = mem_word(b, k);
        end
        last       = t + n - 1;
        hd_last[b] = last;
        t          = t + n + 3;
      end
    end
    if (fc[4]) begin
      done_cyc = 4;
      err_from = 4;
    end else begin
      done_cyc = (last == 0) ? 4 : last + 4;
    end
    end_cyc = done_cyc + 3;
  endtask

  task automatic run_event(input logic [4:0] fc);
    logic [NMEM-1:0] hd_exp;
    obs_nout = 0; obs_done = -1; obs_ndone = 0; obs_first_ov = -1; obs_last_addr = -1;
    obs_blks.delete();
    for (int b = 0; b < NMEM; b++) obs_first_rd[b] = -1;
    seed = $urandom();
    build_model(fc);
    @(negedge clk);
    for (int b = 0; b < NMEM; b++) nent[b*CW +: CW] = CW'(ev_n[b]);
    start      = 1'b1;
    force_code = fc;
    for (int c = 1; c <= end_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      hd_exp = '0;
      for (int b = 0; b < NMEM; b++)
        if (c <= hd_last[b]) hd_exp[b] = 1'b1;
      chk("has_dat", c, 64'(has_dat), 64'(hd_exp));
      chk("rd_en", c, 64'(rd_en), 64'(e_rden[c]));
      if (e_rden[c] != '0) chk("rd_addr", c, 64'(rd_addr), 64'(e_addr[c]));
      chk("out_valid", c, 64'(out_valid), 64'(e_ov[c]));
      if (e_ov[c]) begin
        chk("out_blk", c, 64'(out_blk), 64'(e_ob[c]));
        chk("out_data", c, 64'(out_data), 64'(e_od[c]));
      end
      chk("done", c, 64'(done), 64'(c == done_cyc));
      chk("err", c, 64'(err), 64'(c >= err_from));
      if (out_valid) begin
        obs_nout++;
        obs_blks.push_back(int'(out_blk));
        if (obs_first_ov < 0) obs_first_ov = c;
      end
      for (int b = 0; b < NMEM; b++)
        if (rd_en[b] && obs_first_rd[b] < 0) obs_first_rd[b] = c;
      if (rd_en != '0) obs_last_addr = int'(rd_addr);
      if (done) begin
        obs_ndone++;
        obs_done = c;
      end
    end
    force_code = 5'd0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_n();
    for (int b = 0; b < NMEM; b++) ev_n[b] = 0;
  endtask

  task automatic chk_quiet(input string nm, input int c);
    chk({nm, "_rd_en"}, c, 64'(rd_en), 64'd0);
    chk({nm, "_has_dat"}, c, 64'(has_dat), 64'd0);
    chk({nm, "_out_valid"}, c, 64'(out_valid), 64'd0);
    chk({nm, "_done"}, c, 64'(done), 64'd0);
    chk({nm, "_err"}, c, 64'(err), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset", 0);
    chk("reset_rd_addr", 0, 64'(rd_addr), 64'd0);
    chk("reset_out_data", 0, 64'(out_data), 64'd0);
    chk("reset_out_blk", 0, 64'(out_blk), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // All blocks empty.
    clear_n();
    run_event(5'd0);
    chk("empty_done_cyc", 0, 64'(obs_done), 64'd4);
    chk("empty_nout", 0, 64'(obs_nout), 64'd0);

    // Block 2 with three entries.
    clear_n();
    ev_n[2] = 3;
    run_event(5'd0);
    chk("b2_first_rd", 0, 64'(obs_first_rd[2]), 64'd4);
    chk("b2_first_ov", 0, 64'(obs_first_ov), 64'd6);
    chk("b2_nout", 0, 64'(obs_nout), 64'd3);
    chk("b2_done_cyc", 0, 64'(obs_done), 64'd10);

    // Blocks 0 and 11, one entry each.
    clear_n();
    ev_n[0]  = 1;
    ev_n[11] = 1;
    run_event(5'd0);
    chk("b0_first_rd", 0, 64'(obs_first_rd[0]), 64'd4);
    chk("b11_first_rd", 0, 64'(obs_first_rd[11]), 64'd8);
    chk("order_len", 0, 64'(obs_blks.size()), 64'd2);
    if (obs_blks.size() == 2) begin
      chk("order_0", 0, 64'(obs_blks[0]), 64'd0);
      chk("order_1", 0, 64'(obs_blks[1]), 64'd11);
    end
    chk("b0b11_ndone", 0, 64'(obs_ndone), 64'd1);

    // Block 10 full, no address wrap.
    clear_n();
    ev_n[10] = 64;
    run_event(5'd0);
    chk("b10_nout", 0, 64'(obs_nout), 64'd64);
    chk("b10_last_addr", 0, 64'(obs_last_addr), 64'd63);
    chk("b10_done_cyc", 0, 64'(obs_done), 64'd71);

    // Oversized count saturates.
    clear_n();
    ev_n[3] = 100;
    ev_n[7] = 2;
    run_event(5'd0);
    chk("sat_nout", 0, 64'(obs_nout), 64'd66);

    // Illegal code 1010, then a legal code naming an empty block.
    clear_n();
    ev_n[1] = 5;
    ev_n[4] = 2;
    run_event(5'b1_1010);
    chk("illegal_done_cyc", 0, 64'(obs_done), 64'd4);
    chk("illegal_err_hold", 0, 64'(err), 64'd1);
    clear_n();
    ev_n[1] = 2;
    run_event(5'b1_0101);
    chk("emptysel_done_cyc", 0, 64'(obs_done), 64'd4);

    // Normal event after an error: err must clear on start.
    clear_n();
    ev_n[6] = 4;
    run_event(5'd0);

    for (int e = 0; e < 8; e++) begin
      for (int b = 0; b < NMEM; b++)
        ev_n[b] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 127));
      run_event(5'd0);
    end

    // Reset during READ; start asserted while in reset is ignored.
    clear_n();
    ev_n[0] = 10;
    @(negedge clk);
    for (int b = 0; b < NMEM; b++) nent[b*CW +: CW] = CW'(ev_n[b]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_rd_en", 5, 64'(rd_en), 64'h001);
    reset_n = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    chk_quiet("rst_c6", 6);
    reset_n = 1'b1;
    start   = 1'b0;
    @(negedge clk);
    chk_quiet("rst_c7", 7);
    for (int c = 8; c <= 12; c++) begin
      @(negedge clk);
      chk_quiet("rst_idle", c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stream_reader.md
# mem_stream_reader

Consumer end of the memory-block priority-encoder loop. It is loaded with per-block entry counts at event start and publishes one `has_dat` flag per non-empty block to the encoder. It then decodes the encoder's registered binary `sel`/`none` and drains the chosen block with sequential reads. The result is a single merged data stream plus an end-of-event `done` pulse, and empty blocks cost no read cycles.

## Interface
- `NMEM`, 12, number of memory blocks (fixed at 12; `sel` code map below depends on it)
- `ADDR_W`, 6, memory read address width; max entries per block = 2^ADDR_W
- `DATA_W`, 36, memory word width
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin new event; sampled only in IDLE
- `nent`  in  NMEM*(ADDR_W+1)  entry count per block, block i at bits [i*(ADDR_W+1) +: ADDR_W+1]; sampled with `start`
- `has_dat`  out  NMEM  registered; bit i = block i has unread entries (to encoder)
- `sel`  in  4  encoder's registered binary select
- `none`  in  1  encoder's registered all-empty flag
- `rd_en`  out  NMEM  registered one-hot read enable
- `rd_addr`  out  ADDR_W  registered read address, shared by all blocks
- `rd_data`  in  NMEM*DATA_W  memory outputs, valid 1 cycle after `rd_en`
- `out_data`  out  DATA_W  merged stream word
- `out_blk`  out  4  source block index (0..11) of `out_data`
- `out_valid`  out  1  `out_data`/`out_blk` valid this cycle
- `done`  out  1  one-cycle pulse, event fully drained
- `err`  out  1  sticky; illegal/inconsistent `sel`; cleared by next accepted `start`

## Operation
- State machine: IDLE, SETTLE, DECIDE, READ, DONE.
- Per-block remaining counters `rem[i]` are ADDR_W+1 bits. A `nent` value above 2^ADDR_W saturates to 2^ADDR_W. `has_dat[i]` = (`rem[i]` != 0), registered.
- IDLE → SETTLE on `start`. Loads all `rem`, clears `err`, and resets the settle counter.
- SETTLE: exactly 2 cycles covering the encoder's 2-register latency, then → DECIDE.
- DECIDE, evaluated from `sel`/`none` in this cycle:
  - `none`=1 → DONE.
  - Otherwise decode `sel`: codes 0000–1001 → blocks 0–9; 1011 → block 10; 1100 → block 11.
  - Codes 1010 and 1101–1111 are illegal.
  - An illegal code, or a decoded block with `rem`=0, sets `err`, zeroes all `rem`, and → DONE.
  - A legal code latches block `blk`, sets address to 0, and → READ.
- READ, one read per cycle:
  - Drive `rd_en[blk]`=1 and `rd_addr`=addr; addr+1; `rem[blk]`−1.
  - On the read with `rem[blk]`=1, `has_dat[blk]` falls at the same edge and the state → SETTLE.
  - `sel`/`none` are ignored during READ.
- Return path: `rd_data[blk]` is captured 1 cycle after `rd_en` into `out_data`, with `out_blk`=blk and `out_valid`=1. The return path is a 2-stage pipe independent of the FSM, so reads in flight complete after the state leaves READ.
- DONE: `done`=1 for one cycle → IDLE. `done` is never asserted while any `out_valid` is pending; DONE waits until the return pipe is empty.
- `start` outside IDLE is ignored.

## Timing
- Reset (`reset_n`=0 at an edge): state IDLE. All `rem`, `has_dat`, `rd_en`, `rd_addr`, `out_data`, `out_blk`, `out_valid`, `done`, and `err` are 0. The return pipe is flushed.
- Reset mid-event: reads in flight are discarded, and `out_valid`=0 from the next cycle.
- Cycle numbering: `start`=1 in cycle 0. Then:
  - `has_dat` is valid in cycle 1.
  - SETTLE occupies cycles 1–2.
  - DECIDE is cycle 3.
  - The first `rd_en` is in cycle 4.
  - The first `out_valid` is in cycle 6 (`rd_en` → `out_valid` = 2 cycles).
- Block switch overhead: 3 dead cycles (SETTLE ×2 + DECIDE) between the last read of one block and the first read of the next.
- Throughput within a block is 1 word/cycle.
- `rd_addr` never wraps: at most 2^ADDR_W reads per block, and the last address is 2^ADDR_W−1.

## Test plan
- All `nent`=0, `start` in cycle 0 → `has_dat`=0. `none`=1 is seen in DECIDE at cycle 3, and `done` pulses in cycle 4. No `rd_en`, no `out_valid`.
- Only block 2 with `nent`=3 → `rd_en[2]` in cycles 4–6 with addr 0,1,2. `out_valid` in cycles 6–8 with `out_blk`=2 and data matching. `has_dat[2]` falls in cycle 7. `done` pulses in cycle 10.
- Blocks 0 and 11 with 1 entry each → block 0 is read in cycle 4. Block 11 is read in cycle 8 (`sel`=1100 decodes to 11). Stream order is 0, 11. `done` pulses once.
- Block 10 with `nent`=64, `ADDR_W`=6 → 64 consecutive reads with addr 0..63 and no wrap. `out_blk`=10 throughout (`sel`=1011 decodes to 10).
- Force `sel`=1010 with `none`=0 in DECIDE → `err`=1, `has_dat` all 0 next cycle, `done` pulses. `err` clears on the next `start`.
- Deassert `reset_n` during READ (cycle 5) → all outputs are 0 from cycle 6 and the state is IDLE. A `start` asserted during reset is ignored.
